// File: rtl/fixed_point_multiplier.sv
// Four-stage pipelined signed fixed-point multiplier: full-width product,
// floor-rounding arithmetic rescale, and saturation to the operand format.
module fixed_point_multiplier #(
    parameter int FIXED_POINT_LENGTH   = 16,
    parameter int FIXED_POINT_POSITION = 10
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [FIXED_POINT_LENGTH-1:0] fixed_point_1_in,
    input  logic [FIXED_POINT_LENGTH-1:0] fixed_point_2_in,
    output logic [FIXED_POINT_LENGTH-1:0] product_out
);

    localparam int L    = FIXED_POINT_LENGTH;
    localparam int F    = FIXED_POINT_POSITION;
    localparam int P_W  = 2 * L;
    localparam int LO_W = L / 2;
    localparam int HI_W = L - LO_W;
    localparam int HH_W = 2 * HI_W;
    localparam int HL_W = L + 1;
    localparam int LL_W = 2 * LO_W;
    localparam int TOP_W = P_W - L + 1;

    // Stage 1: operand capture
    logic [L-1:0] a_q, b_q;

    // Stage 2: partial products (signed high halves, unsigned low halves)
    logic signed [HH_W-1:0] pp_hh_q, pp_hh_d;
    logic signed [HL_W-1:0] pp_hl_q, pp_hl_d;
    logic signed [HL_W-1:0] pp_lh_q, pp_lh_d;
    logic        [LL_W-1:0] pp_ll_q, pp_ll_d;

    // Stage 3: full-width product
    logic signed [P_W-1:0] product_q, product_d;

    // Stage 4: rescaled, saturated result
    logic [L-1:0] result_q, result_d;

    logic signed [HI_W-1:0] a_hi, b_hi;
    logic        [LO_W-1:0] a_lo, b_lo;

    assign a_hi = a_q[L-1:LO_W];
    assign b_hi = b_q[L-1:LO_W];
    assign a_lo = a_q[LO_W-1:0];
    assign b_lo = b_q[LO_W-1:0];

    // Every operand is widened to the result width first so no product can wrap.
    always_comb begin
        pp_hh_d = $signed({{HI_W{a_hi[HI_W-1]}}, a_hi})
                * $signed({{HI_W{b_hi[HI_W-1]}}, b_hi});
        pp_hl_d = $signed({{(LO_W+1){a_hi[HI_W-1]}}, a_hi})
                * $signed({{(HI_W+1){1'b0}}, b_lo});
        pp_lh_d = $signed({{(HI_W+1){1'b0}}, a_lo})
                * $signed({{(LO_W+1){b_hi[HI_W-1]}}, b_hi});
        pp_ll_d = {{LO_W{1'b0}}, a_lo} * {{LO_W{1'b0}}, b_lo};
    end

    logic signed [P_W-1:0] hh_ext, hl_ext, lh_ext, ll_ext;

    always_comb begin
        hh_ext    = {{(P_W-HH_W){pp_hh_q[HH_W-1]}}, pp_hh_q};
        hl_ext    = {{(P_W-HL_W){pp_hl_q[HL_W-1]}}, pp_hl_q};
        lh_ext    = {{(P_W-HL_W){pp_lh_q[HL_W-1]}}, pp_lh_q};
        ll_ext    = {{(P_W-LL_W){1'b0}}, pp_ll_q};
        product_d = (hh_ext <<< (2 * LO_W)) + (hl_ext <<< LO_W)
                  + (lh_ext <<< LO_W) + ll_ext;
    end

    logic signed [P_W-1:0] shifted;
    logic [TOP_W-1:0]      top_bits;

    // The result fits iff every bit from the output sign bit upward agrees.
    always_comb begin
        shifted  = product_q >>> F;
        top_bits = shifted[P_W-1:L-1];
        if (top_bits == '0 || top_bits == '1) begin
            result_d = shifted[L-1:0];
        end else if (shifted[P_W-1]) begin
            result_d = {1'b1, {(L-1){1'b0}}};
        end else begin
            result_d = {1'b0, {(L-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_q       <= '0;
            b_q       <= '0;
            pp_hh_q   <= '0;
            pp_hl_q   <= '0;
            pp_lh_q   <= '0;
            pp_ll_q   <= '0;
            product_q <= '0;
            result_q  <= '0;
        end else begin
            a_q       <= fixed_point_1_in;
            b_q       <= fixed_point_2_in;
            pp_hh_q   <= pp_hh_d;
            pp_hl_q   <= pp_hl_d;
            pp_lh_q   <= pp_lh_d;
            pp_ll_q   <= pp_ll_d;
            product_q <= product_d;
            result_q  <= result_d;
        end
    end

    assign product_out = result_q;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Self-checking bench for fixed_point_multiplier: directed corner cases,
// reset behaviour, back-to-back streaming and randomized held operands.
module tb_fixed_point_multiplier;

    localparam int L = 16;
    localparam int F = 10;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [L-1:0]  fixed_point_1_in;
    logic [L-1:0]  fixed_point_2_in;
    logic [L-1:0]  product_out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_in = ~clk_in;

    fixed_point_multiplier #(
        .FIXED_POINT_LENGTH  (L),
        .FIXED_POINT_POSITION(F)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .fixed_point_1_in(fixed_point_1_in),
        .fixed_point_2_in(fixed_point_2_in),
        .product_out     (product_out)
    );

    // Reference: exact integer product, floor division by 2^F, clamp.
    function automatic logic [L-1:0] ref_mul(input logic [L-1:0] a, input logic [L-1:0] b);
        longint pa, pb, p, q, lim_hi, lim_lo;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        q  = p / (longint'(1) << F);
        if ((p % (longint'(1) << F)) != 0 && p < 0) q = q - 1;
        lim_hi = (longint'(1) << (L - 1)) - 1;
        lim_lo = -(longint'(1) << (L - 1));
        if (q > lim_hi) q = lim_hi;
        if (q < lim_lo) q = lim_lo;
        return q[L-1:0];
    endfunction

    task automatic check_eq(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: product_out=0x%04h expected=0x%04h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: product_out=0x%04h", tag, got);
        end
    endtask

    task automatic hold_check(input string tag, input logic [L-1:0] a,
                              input logic [L-1:0] b, input logic [L-1:0] exp);
        @(negedge clk_in);
        fixed_point_1_in = a;
        fixed_point_2_in = b;
        repeat (8) @(posedge clk_in);
        @(negedge clk_in);
        check_eq(tag, product_out, exp);
    endtask

    logic [L-1:0] sat_vals [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [L-1:0] stream_a [3] = '{16'h0400, 16'hFC00, 16'h8000};
    logic [L-1:0] stream_b [3] = '{16'h0C00, 16'h0200, 16'h8000};
    logic [L-1:0] stream_e [3] = '{16'h0C00, 16'hFE00, 16'h7FFF};

    initial begin
        logic [L-1:0] exp_q [$];
        logic [L-1:0] ra, rb, e;

        rst_in           = 1'b1;
        fixed_point_1_in = 16'h1234;
        fixed_point_2_in = 16'h5678;
        #1;
        check_eq("reset_state", product_out, 16'h0000);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Directed values, plus operand swap for symmetry
        hold_check("one_x_three",      16'h0400, 16'h0C00, 16'h0C00);
        hold_check("neg_one_x_half",   16'hFC00, 16'h0200, 16'hFE00);
        hold_check("half_x_neg_one",   16'h0200, 16'hFC00, 16'hFE00);
        hold_check("zero_x_any",       16'h0000, 16'h9ABC, 16'h0000);
        hold_check("floor_m1_m1",      16'hFFFF, 16'hFFFF, 16'h0000);
        hold_check("floor_m1_max",     16'hFFFF, 16'h7FFF, 16'hFFE0);
        hold_check("floor_m1_min",     16'hFFFF, 16'h8000, 16'h0020);
        hold_check("sat_min_min",      16'h8000, 16'h8000, 16'h7FFF);
        hold_check("sat_max_max",      16'h7FFF, 16'h7FFF, 16'h7FFF);
        hold_check("sat_min_max",      16'h8000, 16'h7FFF, 16'h8000);
        hold_check("sat_max_min",      16'h7FFF, 16'h8000, 16'h8000);

        foreach (sat_vals[i]) begin
            foreach (sat_vals[j]) begin
                hold_check($sformatf("sat_pair_%0d_%0d", i, j), sat_vals[i], sat_vals[j],
                           ref_mul(sat_vals[i], sat_vals[j]));
            end
        end

        // Asynchronous reset mid-stream, then recovery latency
        hold_check("pre_reset", 16'h0400, 16'h0C00, 16'h0C00);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1 check_eq("async_reset", product_out, 16'h0000);
        @(posedge clk_in);
        @(negedge clk_in);
        check_eq("reset_held", product_out, 16'h0000);
        rst_in           = 1'b0;
        fixed_point_1_in = 16'hFC00;
        fixed_point_2_in = 16'h0200;
        repeat (3) @(negedge clk_in);
        check_eq("post_reset_flush", product_out, 16'h0000);
        @(negedge clk_in);
        check_eq("post_reset_first", product_out, 16'hFE00);
        repeat (4) @(negedge clk_in);
        check_eq("post_reset_stable", product_out, 16'hFE00);

        // Back-to-back operands: result of negedge k's inputs appears at negedge k+4
        exp_q.delete();
        for (int i = 0; i < 203 + 4; i++) begin
            @(negedge clk_in);
            if (i >= 4) begin
                e = exp_q.pop_front();
                check_eq($sformatf("stream_%0d", i - 4), product_out, e);
            end
            if (i < 3) begin
                ra = stream_a[i];
                rb = stream_b[i];
                exp_q.push_back(stream_e[i]);
            end else begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                exp_q.push_back(ref_mul(ra, rb));
            end
            fixed_point_1_in = ra;
            fixed_point_2_in = rb;
        end

        // Randomized held operands, biased toward small magnitudes a third of the time
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ((n % 3) == 0) begin
                ra = 16'($signed(16'($urandom_range(0, 8191))) - 16'sd4096);
                rb = 16'($signed(16'($urandom_range(0, 8191))) - 16'sd4096);
            end
            hold_check($sformatf("rand_%0d_%04h_%04h", n, ra, rb), ra, rb, ref_mul(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
